fetch_pc_unit: RTL and testbench
================================

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h00000000, PC value loaded on reset; bits [1:0] SHALL be 0.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  reset, synchronous, active-high.
REQ-004 Port: branch  in  1  branch instruction in EXE stage.
REQ-005 Port: Zero_signal  in  1  EXE ALU zero flag.
REQ-006 Port: branch_target  in  32  EXE branch target address.
REQ-007 Port: stall  in  1  downstream cannot accept the presented instruction.
REQ-008 Port: imem_ack  in  1  instruction memory returns data this cycle.
REQ-009 Port: imem_rdata  in  32  instruction word, valid when imem_ack=1.
REQ-010 Port: imem_req  out  1  fetch request.
REQ-011 Port: imem_addr  out  32  fetch address.
REQ-012 Port: pc  out  32  address of the current or presented instruction.
REQ-013 Port: PCNext  out  32  pc+4, combinational, feeds EXE branch adder.
REQ-014 Port: instr  out  32  registered fetched instruction.
REQ-015 Port: instr_valid  out  1  instr is valid for downstream.
REQ-016 Port: align_err  out  1  sticky: misaligned branch target seen.

Function
REQ-017 FSM states: IDLE, REQ, DONE; taken = branch & Zero_signal.
REQ-018 IDLE: imem_req=0; next cycle -> REQ.
REQ-019 REQ: imem_req=1, imem_addr=pc; both held stable until imem_ack; only one request outstanding.
REQ-020 REQ with imem_ack and no squash pending: instr<=imem_rdata, instr_valid=1 from the next cycle (1-cycle latency), -> DONE.
REQ-021 DONE with stall=1: hold pc, instr, instr_valid=1; imem_req=0.
REQ-022 DONE with stall=0 and no taken: pc<=pc+4, instr_valid<=0, -> REQ.
REQ-023 taken in IDLE or DONE: pc<=branch_target, instr_valid<=0, -> REQ; taken overrides stall.
REQ-024 taken in REQ before ack: latch branch_target, set squash flag, keep imem_req/imem_addr unchanged; on ack discard data, leave instr_valid=0, pc<=latched target, clear squash, -> REQ.
REQ-025 taken in the same cycle as imem_ack in REQ: discard data, pc<=branch_target, -> REQ.
REQ-026 Second taken while squash pending: newer target replaces latched one.
REQ-027 taken with branch_target[1:0]!=0: redirect ignored (treated as not taken), align_err<=1 until reset.
REQ-028 PC arithmetic modulo 2^32: 32'hFFFFFFFC + 4 = 32'h00000000, no error.
REQ-029 PCNext = pc + 4 at all times, including while stalled.

Reset
REQ-030 rst=1 at a clock edge: state<=IDLE, pc<=RESET_PC, instr<=0, instr_valid<=0, align_err<=0, squash<=0; overrides all other inputs.
REQ-031 Reset mid-request: imem_req drops the cycle after rst edge; a late imem_ack while in IDLE SHALL be ignored.
REQ-032 Outputs after reset: imem_req=0, imem_addr=RESET_PC, pc=RESET_PC, PCNext=RESET_PC+4.

Structure
REQ-033 Shared package holds FSM state encoding, PC_STEP=4, and RESET_PC default.
REQ-034 One sub-module: pc_incr (32-bit +4 adder, carry out unused), reused for PCNext and sequential increment.
REQ-035 No clock gating; all registers in the clk domain.

Verification
REQ-036 Reset, ack 2 cycles after req, stall=0: imem_addr sequence 0,4,8; instr_valid pulses 1 cycle after each ack.
REQ-037 DONE, stall=1 for 3 cycles: pc, instr held, instr_valid=1, imem_req=0; release -> req at pc+4.
REQ-038 pc=0x10 in REQ, branch=1, Zero_signal=1, target 0x40, ack 2 cycles later: data discarded, instr_valid stays 0, next req addr 0x40.
REQ-039 branch=1, Zero_signal=0 in DONE: no redirect, next addr pc+4; branch=1, Zero_signal=1, target 0x42: align_err=1, next addr pc+4.
REQ-040 RESET_PC=0xFFFFFFFC: second fetch addr 0x00000000; PCNext at reset = 0x00000000.
REQ-041 rst asserted while imem_req=1: next cycle imem_req=0, pc=RESET_PC; ack arriving in IDLE produces no instr_valid.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the instruction fetch PC unit: FSM encoding and PC constants.
package fetch_pc_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_unit_incr.sv
// Sequential-PC adder; the single instance serves both PCNext and the pc+4 update.
module pc_incr
  import fetch_pc_unit_pkg::*;
(
  input  logic [31:0] i_pc,
  output logic [31:0] o_pc_next
);

  // Wraps modulo 2^32; carry out is intentionally dropped.
  assign o_pc_next = i_pc + PC_STEP;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC sequencer: one outstanding imem request, branch redirect with squash.
//  state  | meaning
//  S_IDLE | after reset, no request; late acks ignored
//  S_REQ  | request at pc outstanding, waiting for imem_ack
//  S_DONE | instr presented to downstream, held while stalled
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch,
  input  logic        Zero_signal,
  input  logic [31:0] branch_target,
  input  logic        stall,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] PCNext,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        align_err
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic         r_instr_valid;
  logic         r_align_err;
  logic         r_squash;
  logic [31:0]  r_squash_tgt;

  logic [31:0]  w_pc_plus4;
  logic         w_taken;
  logic         w_tgt_aligned;
  logic         w_redirect;
  logic         w_misalign;

  pc_incr u_pc_incr (
    .i_pc      (r_pc),
    .o_pc_next (w_pc_plus4)
  );

  assign w_taken       = branch & Zero_signal;
  assign w_tgt_aligned = (branch_target[1:0] == 2'b00);
  assign w_redirect    = w_taken & w_tgt_aligned;
  assign w_misalign    = w_taken & ~w_tgt_aligned;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= 32'd0;
      r_instr_valid <= 1'b0;
      r_align_err   <= 1'b0;
      r_squash      <= 1'b0;
      r_squash_tgt  <= 32'd0;
    end else begin
      if (w_misalign) r_align_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
          if (w_redirect) r_pc <= branch_target;
        end
        S_REQ: begin
          if (imem_ack) begin
            if (w_redirect) begin
              r_pc     <= branch_target;
              r_squash <= 1'b0;
            end else if (r_squash) begin
              r_pc     <= r_squash_tgt;
              r_squash <= 1'b0;
            end else begin
              r_instr       <= imem_rdata;
              r_instr_valid <= 1'b1;
              r_state       <= S_DONE;
            end
          end else if (w_redirect) begin
            // Address must stay stable until ack, so remember the newest target.
            r_squash     <= 1'b1;
            r_squash_tgt <= branch_target;
          end
        end
        S_DONE: begin
          if (w_redirect) begin
            r_pc          <= branch_target;
            r_instr_valid <= 1'b0;
            r_state       <= S_REQ;
          end else if (!stall) begin
            r_pc          <= w_pc_plus4;
            r_instr_valid <= 1'b0;
            r_state       <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req    = (r_state == S_REQ);
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign PCNext      = w_pc_plus4;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign align_err   = r_align_err;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit; a second instance with a wrapping RESET_PC shares stimulus.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst, branch, Zero_signal, stall, imem_ack;
  logic [31:0] branch_target, imem_rdata;
  logic        imem_req, instr_valid, align_err;
  logic [31:0] imem_addr, pc, PCNext, instr;
  logic        wr_imem_req, wr_instr_valid, wr_align_err;
  logic [31:0] wr_imem_addr, wr_pc, wr_PCNext, wr_instr;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_pc_unit dut (
    .clk(clk), .rst(rst), .branch(branch), .Zero_signal(Zero_signal),
    .branch_target(branch_target), .stall(stall), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .imem_req(imem_req), .imem_addr(imem_addr),
    .pc(pc), .PCNext(PCNext), .instr(instr), .instr_valid(instr_valid),
    .align_err(align_err)
  );

  fetch_pc_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .branch(branch), .Zero_signal(Zero_signal),
    .branch_target(branch_target), .stall(stall), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .imem_req(wr_imem_req), .imem_addr(wr_imem_addr),
    .pc(wr_pc), .PCNext(wr_PCNext), .instr(wr_instr), .instr_valid(wr_instr_valid),
    .align_err(wr_align_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request already visible at addr; ack arrives two cycles later.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data);
    for (int i = 0; i < 2; i++) begin
      chk("req_held", {31'd0, imem_req}, 32'd1);
      chk("addr_held", imem_addr, addr);
      tick();
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack   = 1'b0;
    chk("valid_after_ack", {31'd0, instr_valid}, 32'd1);
    chk("instr_after_ack", instr, data);
    chk("req_in_done", {31'd0, imem_req}, 32'd0);
  endtask

  task automatic take(input logic z, input logic [31:0] tgt);
    branch        = 1'b1;
    Zero_signal   = z;
    branch_target = tgt;
  endtask

  task automatic no_branch();
    branch        = 1'b0;
    Zero_signal   = 1'b0;
    branch_target = 32'd0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
    no_branch();
    tick();
    tick();
    rst = 1'b0;

    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_pcnext", PCNext, 32'd4);
    chk("rst_instr", instr, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_align", {31'd0, align_err}, 32'd0);
    chk("wrap_rst_addr", wr_imem_addr, 32'hFFFF_FFFC);
    chk("wrap_rst_pcnext", wr_PCNext, 32'd0);

    tick();
    fetch(32'h0, 32'h1111_0000);
    tick();
    chk("seq_addr4", imem_addr, 32'h4);
    chk("seq_valid_drop", {31'd0, instr_valid}, 32'd0);
    chk("wrap_second_addr", wr_imem_addr, 32'h0);
    fetch(32'h4, 32'h2222_0000);
    tick();
    chk("seq_addr8", imem_addr, 32'h8);

    fetch(32'h8, 32'h3333_0000);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", pc, 32'h8);
      chk("stall_instr", instr, 32'h3333_0000);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      chk("stall_pcnext", PCNext, 32'hC);
    end
    stall = 1'b0;
    tick();
    chk("stall_release_addr", imem_addr, 32'hC);
    chk("stall_release_req", {31'd0, imem_req}, 32'd1);

    fetch(32'hC, 32'h4444_0000);
    tick();
    chk("pc10_addr", imem_addr, 32'h10);
    take(1'b1, 32'h40);
    tick();
    no_branch();
    chk("squash_req_held", {31'd0, imem_req}, 32'd1);
    chk("squash_addr_held", imem_addr, 32'h10);
    tick();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    chk("squash_valid", {31'd0, instr_valid}, 32'd0);
    chk("squash_instr_kept", instr, 32'h4444_0000);
    chk("squash_next_addr", imem_addr, 32'h40);
    chk("squash_next_req", {31'd0, imem_req}, 32'd1);

    take(1'b1, 32'h100);
    tick();
    take(1'b1, 32'h200);
    tick();
    no_branch();
    chk("double_squash_held", imem_addr, 32'h40);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("newest_target", imem_addr, 32'h200);
    chk("newest_valid", {31'd0, instr_valid}, 32'd0);

    take(1'b1, 32'h300);
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    tick();
    no_branch();
    imem_ack = 1'b0;
    chk("ack_taken_addr", imem_addr, 32'h300);
    chk("ack_taken_valid", {31'd0, instr_valid}, 32'd0);
    chk("ack_taken_instr", instr, 32'h4444_0000);

    fetch(32'h300, 32'h5555_0000);
    take(1'b0, 32'h500);
    tick();
    no_branch();
    chk("not_taken_addr", imem_addr, 32'h304);
    fetch(32'h304, 32'h6666_0000);
    take(1'b1, 32'h42);
    tick();
    no_branch();
    chk("misalign_addr", imem_addr, 32'h308);
    chk("misalign_err", {31'd0, align_err}, 32'd1);
    fetch(32'h308, 32'h7777_0000);
    stall = 1'b1;
    take(1'b1, 32'h600);
    tick();
    no_branch();
    stall = 1'b0;
    chk("taken_over_stall_addr", imem_addr, 32'h600);
    chk("taken_over_stall_valid", {31'd0, instr_valid}, 32'd0);
    chk("align_sticky", {31'd0, align_err}, 32'd1);

    chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midreq_rst_req", {31'd0, imem_req}, 32'd0);
    chk("midreq_rst_pc", pc, 32'd0);
    chk("midreq_rst_align", {31'd0, align_err}, 32'd0);
    chk("midreq_rst_pcnext", PCNext, 32'd4);
    imem_ack = 1'b1; imem_rdata = 32'h9999_9999;
    tick();
    imem_ack = 1'b0;
    chk("late_ack_valid", {31'd0, instr_valid}, 32'd0);
    chk("late_ack_instr", instr, 32'd0);
    chk("late_ack_req", {31'd0, imem_req}, 32'd1);
    chk("late_ack_addr", imem_addr, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
